// File: rtl/spi_pkg.sv
// Shared state encoding, mode constants and default widths for the SPI serial-clock engine.
// Latency: n/a (types only); backpressure: n/a.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        RUN   = 2'd2,
        HOLD  = 2'd3
    } spi_state_t;

    localparam logic CPOL0 = 1'b0;
    localparam logic CPOL1 = 1'b1;
    localparam logic CPHA0 = 1'b0;
    localparam logic CPHA1 = 1'b1;

    localparam int DEF_DIV_W = 8;
    localparam int DEF_NB_W  = 6;

endpackage

// File: rtl/spi_halfper_cnt.sv
// Half-period counter: counts 0..i_div and wraps; o_tc marks the last cycle of a half-period.
// Latency: o_tc is combinational from the count, i_clr lands next cycle; no backpressure.
module spi_halfper_cnt #(
    parameter int DIV_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic [DIV_W-1:0] i_div,
    output logic             o_tc
);

    logic [DIV_W-1:0] cnt;

    assign o_tc = (cnt == i_div);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt <= '0;
        end else if (i_clr || o_tc) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/spi_sclk_engine.sv
// SPI SCLK generator with CPOL/CPHA, bit count, lead/lag guard and load/shift/sample strobes.
// Latency: all outputs registered, o_load one cycle after start; inputs ignored while busy.
module spi_sclk_engine
    import spi_pkg::*;
#(
    parameter int DIV_W = DEF_DIV_W,
    parameter int NB_W  = DEF_NB_W
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic [DIV_W-1:0] i_divider,
    input  logic [NB_W-1:0]  i_nbits,
    input  logic             i_cpol,
    input  logic             i_cpha,
    output logic             o_sclk,
    output logic             o_lead_edge,
    output logic             o_trail_edge,
    output logic             o_load,
    output logic             o_shift,
    output logic             o_sample,
    output logic [NB_W-1:0]  o_bit_cnt,
    output logic             o_busy,
    output logic             o_done
);

    spi_state_t       state;
    logic [DIV_W-1:0] div_q;
    logic [NB_W-1:0]  nbits_q;
    logic             cpol_q;
    logic             cpha_q;
    logic [NB_W:0]    edge_cnt;

    logic             hc_tc;
    logic             hc_clr;
    logic [NB_W:0]    next_edge;
    logic             is_last;
    logic             sample_now;
    logic             shift_now;

    assign next_edge = edge_cnt + (NB_W+1)'(1);
    assign is_last   = (next_edge == {nbits_q, 1'b0});

    // Odd edges are leading, even edges trailing; CPHA picks which kind samples.
    always_comb begin
        sample_now = 1'b0;
        shift_now  = 1'b0;
        if (cpha_q == CPHA0) begin
            sample_now = next_edge[0];
            shift_now  = !next_edge[0] && !is_last;
        end else begin
            sample_now = !next_edge[0];
            shift_now  = next_edge[0] && (next_edge != (NB_W+1)'(1));
        end
    end

    // The half-period count restarts on every state change, including abort.
    always_comb begin
        hc_clr = 1'b1;
        case (state)
            IDLE:        hc_clr = 1'b1;
            SETUP, HOLD: hc_clr = i_abort || hc_tc;
            RUN:         hc_clr = i_abort || (hc_tc && is_last);
            default:     hc_clr = 1'b1;
        endcase
    end

    spi_halfper_cnt #(
        .DIV_W (DIV_W)
    ) u_halfper_cnt (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_clr (hc_clr),
        .i_div (div_q),
        .o_tc  (hc_tc)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state        <= IDLE;
            div_q        <= '0;
            nbits_q      <= '0;
            cpol_q       <= 1'b0;
            cpha_q       <= 1'b0;
            edge_cnt     <= '0;
            o_sclk       <= 1'b0;
            o_lead_edge  <= 1'b0;
            o_trail_edge <= 1'b0;
            o_load       <= 1'b0;
            o_shift      <= 1'b0;
            o_sample     <= 1'b0;
            o_bit_cnt    <= '0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
        end else begin
            o_lead_edge  <= 1'b0;
            o_trail_edge <= 1'b0;
            o_load       <= 1'b0;
            o_shift      <= 1'b0;
            o_sample     <= 1'b0;
            o_done       <= 1'b0;
            case (state)
                IDLE: begin
                    o_sclk <= i_cpol;
                    if (i_start && !i_abort) begin
                        if (i_nbits == '0) begin
                            o_done <= 1'b1;
                        end else begin
                            div_q     <= i_divider;
                            nbits_q   <= i_nbits;
                            cpol_q    <= i_cpol;
                            cpha_q    <= i_cpha;
                            edge_cnt  <= '0;
                            o_bit_cnt <= '0;
                            o_load    <= 1'b1;
                            o_busy    <= 1'b1;
                            state     <= SETUP;
                        end
                    end
                end
                default: begin
                    if (i_abort) begin
                        o_sclk <= cpol_q;
                        o_busy <= 1'b0;
                        state  <= IDLE;
                    end else if (hc_tc) begin
                        if (state == HOLD) begin
                            o_busy <= 1'b0;
                            o_done <= 1'b1;
                            state  <= IDLE;
                        end else begin
                            o_sclk       <= ~o_sclk;
                            edge_cnt     <= next_edge;
                            o_lead_edge  <= next_edge[0];
                            o_trail_edge <= ~next_edge[0];
                            o_sample     <= sample_now;
                            o_shift      <= shift_now;
                            if (sample_now) begin
                                o_bit_cnt <= o_bit_cnt + NB_W'(1);
                            end
                            state <= is_last ? HOLD : RUN;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/spi_sclk_engine.md
Name: spi_sclk_engine

Overview:
- Parametrised next-generation SPI serial-clock generator for the SPI master datapath; replaces the fixed-width divider with a transfer-aware engine.
- Produces SCLK with programmable CPOL/CPHA, programmable bit count, and lead/lag guard time around the burst.
- Emits one-cycle load, shift and sample strobes to the shift register, plus busy/done handshake to the controller.
- Runs entirely on i_clk. SCLK half-period is an integer number of i_clk cycles, so there is no dual-edge logic.

Parameters:
- DIV_W, 8, width of i_divider; SCLK half-period = i_divider+1 i_clk cycles.
- NB_W, 6, width of i_nbits and o_bit_cnt; max transfer 2^NB_W-1 bits.

Ports:
- i_clk  in  1  system clock; all logic on its rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_start  in  1  start request; sampled only in IDLE.
- i_abort  in  1  abort current transfer.
- i_divider  in  DIV_W  half-period minus one; latched at start.
- i_nbits  in  NB_W  bits per transfer; latched at start.
- i_cpol  in  1  idle SCLK level; latched at start, followed in IDLE.
- i_cpha  in  1  0 = sample on leading edge, 1 = sample on trailing edge; latched at start.
- o_sclk  out  1  serial clock, registered.
- o_lead_edge  out  1  pulse in the first cycle o_sclk shows its active (non-idle) level.
- o_trail_edge  out  1  pulse in the first cycle o_sclk returns to its idle level.
- o_load  out  1  pulse telling the shift register to present bit 0.
- o_shift  out  1  pulse telling the shift register to advance to the next bit.
- o_sample  out  1  pulse telling the shift register to capture MISO.
- o_bit_cnt  out  NB_W  count of sample strobes issued in the current transfer.
- o_busy  out  1  transfer in progress.
- o_done  out  1  one-cycle completion pulse.

Behaviour:
- Reset: every output is 0; state is IDLE; latched config is 0. The first cycle after reset release o_sclk <= i_cpol.
- Four states: IDLE, SETUP, RUN, HOLD. A half-period counter hc counts 0..div and is cleared on every state change.
- IDLE:
  - o_sclk tracks i_cpol one cycle late; o_busy = 0.
  - On i_start and !i_abort with nbits != 0: latch config, go to SETUP, and in the next cycle o_load = 1, o_busy = 1, o_bit_cnt = 0.
  - On i_start with nbits == 0: no state change; o_done pulses next cycle; no other strobes.
- SETUP: when hc == div, o_sclk toggles next cycle and the state becomes RUN.
- RUN:
  - Every div+1 cycles o_sclk toggles and an edge counter increments. The edge counter is NB_W+1 bits wide.
  - After edge number 2*nbits the state becomes HOLD.
- HOLD: when hc == div, o_done = 1 and o_busy = 0 next cycle, and the state becomes IDLE.
- Edge pulses are registered and coincide with the first cycle of the new o_sclk level:
  - odd-numbered edges give o_lead_edge;
  - even-numbered edges give o_trail_edge.
- Strobes by mode:
  - CPHA=0: o_sample on every lead edge; o_shift on trail edges 1..nbits-1 (none on the last trail edge).
  - CPHA=1: o_shift on lead edges 2..nbits; o_sample on every trail edge.
  - Totals per transfer: exactly nbits samples and nbits-1 shifts.
- o_bit_cnt increments in the same cycle as each o_sample pulse and holds its value until the next start.
- Abort: in any non-IDLE state, i_abort forces IDLE next cycle, with o_sclk = latched cpol, o_busy = 0, no o_done, and all strobes 0. In IDLE it blocks a simultaneous i_start.
- Input changes while busy are ignored, including i_start and config.
- Asynchronous i_rst mid-transfer returns everything to reset values immediately.

Decomposition:
- Package spi_pkg holds:
  - the state enum (IDLE/SETUP/RUN/HOLD);
  - mode constants CPOL0/CPOL1 and CPHA0/CPHA1;
  - default DIV_W and NB_W.
- Sub-module spi_halfper_cnt (DIV_W): a loadable half-period counter with clear input and terminal-count output. The engine instantiates it once.

Test Plan:
- Baseline, div=1, nbits=2, cpol=0, cpha=0, start at T0:
  - T1: o_load, o_busy.
  - o_sclk rises T3, falls T5, rises T7, falls T9.
  - o_sample at T3 and T7; o_shift at T5 only.
  - o_done at T11, o_busy low at T11, o_bit_cnt = 2.
- Mode 3, div=0, nbits=8, cpol=1, cpha=1:
  - o_sclk idles high and toggles every cycle.
  - 7 o_shift pulses on lead edges 2..8; 8 o_sample pulses on trail edges.
  - o_sclk ends high.
- Max divider and width, div=255, nbits=63: each half-period is exactly 256 cycles; 126 edges; o_bit_cnt = 63; no counter wrap.
- Abort at the 3rd edge, div=3:
  - next cycle o_sclk = cpol, o_busy = 0, no o_done;
  - a fresh start 2 cycles later runs a full clean transfer.
- Edge cases:
  - start with nbits=0 gives o_done one cycle later and no SCLK activity;
  - start+abort together in IDLE does nothing;
  - i_start and i_divider changes mid-transfer have no effect.
- Assert i_rst at a random point mid-RUN: all outputs go to 0 asynchronously; after release the block returns to IDLE with o_sclk = i_cpol.
